regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter sitting in front of the single write port of `register_file`. It accepts write requests from two producers (port 0: ALU/execute, port 1: load unit) over valid/ready handshakes. Each request is held in a one-entry buffer per port, and one write per cycle is granted to the register file under age-then-round-robin priority. It also publishes a per-register pending mask so the hazard logic can stall reads of registers with writes still in flight.

## Interface
Parameters:
- `DATA_WIDTH`, 32, write data width
- `REG_ADDR_WIDTH`, 5, register index width; `NUM_REGS` = 2**REG_ADDR_WIDTH

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  port 0 request valid
- `req0_ready`  out  1  port 0 can accept this cycle
- `req0_reg`  in  REG_ADDR_WIDTH  port 0 destination register
- `req0_data`  in  DATA_WIDTH  port 0 write data
- `req1_valid`, `req1_ready`, `req1_reg`, `req1_data`: same as port 0, for port 1
- `wr_en`  out  1  to `register_file.wr_en`
- `wr_reg`  out  REG_ADDR_WIDTH  to `register_file.wr_reg`
- `wr_data`  out  DATA_WIDTH  to `register_file.wr_data`
- `pending_mask`  out  NUM_REGS  bit r set while a buffered write to r is not yet committed

One clock; reset is synchronous and active-high.

## Operation
- Handshake on port N: accepted when `reqN_valid && reqN_ready` at a rising edge.
- `reqN_ready = !bufN_valid || grantN`. It is combinational from buffer state and the current grant, so a drained buffer refills on the same edge.
- A request with `reqN_reg == 0` is accepted and discarded.
  - It is never buffered.
  - It never sets `pending_mask`.
  - It never asserts `wr_en`.
- A nonzero request loads `bufN` (reg, data) and sets its age stamp.
  - The age stamp marks port 0 as older when both ports load on the same edge.
  - Otherwise the entry that was already buffered is older.
- Grant, evaluated combinationally each cycle:
  - Neither buffer valid: no grant, `wr_en = 0`.
  - One buffer valid: grant it.
  - Both valid, same `reg`: grant the older entry, so program order of writes to one register is preserved.
  - Both valid, different `reg`: grant `rr_ptr`'s port.
- `wr_en/wr_reg/wr_data` are driven combinationally from the granted buffer. When `wr_en = 0`, `wr_reg` and `wr_data` hold 0.
- On the edge ending a granted cycle:
  - the granted buffer clears, unless it is refilled by a simultaneous accept;
  - `rr_ptr` becomes the non-granted port;
  - age stamps update.
- `pending_mask[r] = (buf0_valid && buf0_reg == r) | (buf1_valid && buf1_reg == r)`. Bit 0 is always 0.
- Reset:
  - buffers are emptied and all buffered writes are dropped, including mid-operation;
  - `rr_ptr = 0`, `wr_en = 0`, `pending_mask = 0`, readies = 1.

## Timing
- Latency: a request accepted at edge E is presented on `wr_*` in cycle E..E+1. With no competition, it commits into `register_file` at edge E+1.
- Worst case, with both ports saturated: a buffered entry waits at most one extra cycle.
- Throughput: one committed write per cycle; each port sustains one accept per cycle when it wins every grant.
- `pending_mask` rises the cycle after accept and falls the cycle after commit. There is no combinational path from `reqN_*` to `pending_mask`.
- `rst` asserted on an edge overrides any accept or grant on that edge.

## Configuration
- `REGFILE_WB_ARB_STATS_EN`: when defined, three extra outputs are compiled in.
  - `stat_grant0` and `stat_grant1` (32-bit): count committed grants per port.
  - `stat_conflict` (32-bit): counts cycles with both buffers valid.
  - All three are reset to 0 by `rst` and wrap at 2^32.
- When undefined, these ports and counters do not exist. Arbitration behaviour is identical in both builds.

## Test plan
- Single write: port 0 sends reg 5, data 0xDEADBEEF at edge E. Required: `pending_mask[5] = 1` in cycle E+1, `wr_en = 1`, `wr_reg = 5`; `register_file` reads 0xDEADBEEF after E+1, and mask bit 5 clears.
- x0 discard: port 1 sends reg 0, data 0xFFFFFFFF. Required: `req1_ready = 1`, `wr_en` never asserts, `pending_mask = 0`, x0 reads 0.
- Round-robin: both ports stream 4 back-to-back requests to distinct regs (port 0 regs 1-4, port 1 regs 11-14) after reset. Required: commit order is 1, 11, 2, 12, 3, 13, 4, 14, and each port's ready toggles every other cycle.
- Same-register ordering: port 1 buffers reg 7 = 0x1 one cycle before port 0 buffers reg 7 = 0x2, with `rr_ptr = 0`. Required: port 1 commits first, and the final reg 7 value is 0x2.
- Reset mid-operation: with both buffers full, assert `rst` for one edge. Required: neither write commits, `pending_mask = 0`, both readies are 1, and the targeted regs keep their prior values.
- Stats build, with the macro defined: run the round-robin scenario. Required: `stat_grant0 = 4`, `stat_grant1 = 4`, `stat_conflict` equals the number of cycles both buffers were valid (7).

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Two-port write-back arbiter for the single register_file
//               write port. Each producer has a one-entry buffer. One write
//               per cycle is granted: an older entry wins when both target
//               the same register, otherwise a round-robin pointer decides.
//               A per-register pending mask exposes in-flight writes.
//               Optional build macro REGFILE_WB_ARB_STATS_EN adds grant and
//               conflict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     req0_reg,
    input  logic [DATA_WIDTH-1:0]         req0_data,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     req1_reg,
    input  logic [DATA_WIDTH-1:0]         req1_data,
    output logic                          wr_en,
    output logic [REG_ADDR_WIDTH-1:0]     wr_reg,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [2**REG_ADDR_WIDTH-1:0]  pending_mask
`ifdef REGFILE_WB_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_grant0,
    output logic [31:0]                   stat_grant1,
    output logic [31:0]                   stat_conflict
`endif
);

    localparam int                        c_NUM_REGS = 2**REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] c_REG_ZERO = '0;

    // Buffered entries, age flag (1: buffer 1 holds the older entry) and
    // round-robin pointer (port that wins a different-register conflict).
    logic                      r_buf0_valid;
    logic [REG_ADDR_WIDTH-1:0] r_buf0_reg;
    logic [DATA_WIDTH-1:0]     r_buf0_data;
    logic                      r_buf1_valid;
    logic [REG_ADDR_WIDTH-1:0] r_buf1_reg;
    logic [DATA_WIDTH-1:0]     r_buf1_data;
    logic                      r_buf1_older;
    logic                      r_rr_ptr;

    logic w_grant0;
    logic w_grant1;
    logic w_load0;
    logic w_load1;

    // Grant selection; reset suppresses any grant so nothing commits on a reset edge.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst) begin
            if (r_buf0_valid && r_buf1_valid) begin
                if (r_buf0_reg == r_buf1_reg) begin
                    w_grant0 = !r_buf1_older;
                    w_grant1 = r_buf1_older;
                end else begin
                    w_grant0 = !r_rr_ptr;
                    w_grant1 = r_rr_ptr;
                end
            end else begin
                w_grant0 = r_buf0_valid;
                w_grant1 = r_buf1_valid;
            end
        end
    end

    assign req0_ready = !r_buf0_valid || w_grant0;
    assign req1_ready = !r_buf1_valid || w_grant1;

    // Writes to x0 are accepted but never enter a buffer.
    assign w_load0 = req0_valid && req0_ready && (req0_reg != c_REG_ZERO);
    assign w_load1 = req1_valid && req1_ready && (req1_reg != c_REG_ZERO);

    // Drive the register file write port from the granted buffer.
    always_comb begin
        wr_en   = 1'b0;
        wr_reg  = '0;
        wr_data = '0;
        if (w_grant0) begin
            wr_en   = 1'b1;
            wr_reg  = r_buf0_reg;
            wr_data = r_buf0_data;
        end else if (w_grant1) begin
            wr_en   = 1'b1;
            wr_reg  = r_buf1_reg;
            wr_data = r_buf1_data;
        end
    end

    // Buffer fill/drain, round-robin pointer and age tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf0_valid <= 1'b0;
            r_buf0_reg   <= '0;
            r_buf0_data  <= '0;
            r_buf1_valid <= 1'b0;
            r_buf1_reg   <= '0;
            r_buf1_data  <= '0;
            r_buf1_older <= 1'b0;
            r_rr_ptr     <= 1'b0;
        end else begin
            if (w_load0) begin
                r_buf0_valid <= 1'b1;
                r_buf0_reg   <= req0_reg;
                r_buf0_data  <= req0_data;
            end else if (w_grant0) begin
                r_buf0_valid <= 1'b0;
            end

            if (w_load1) begin
                r_buf1_valid <= 1'b1;
                r_buf1_reg   <= req1_reg;
                r_buf1_data  <= req1_data;
            end else if (w_grant1) begin
                r_buf1_valid <= 1'b0;
            end

            // Pointer moves to the port that lost this grant.
            if (w_grant0 || w_grant1) begin
                r_rr_ptr <= w_grant0;
            end

            // Simultaneous loads make port 0 older; a single load is younger
            // than whatever the other buffer already holds.
            if (w_load0 && w_load1) begin
                r_buf1_older <= 1'b0;
            end else if (w_load0) begin
                r_buf1_older <= 1'b1;
            end else if (w_load1) begin
                r_buf1_older <= 1'b0;
            end
        end
    end

    // Pending mask: one comparator pair per register, x0 tied low.
    for (genvar r = 0; r < c_NUM_REGS; r++) begin : g_mask
        if (r == 0) begin : g_zero
            assign pending_mask[r] = 1'b0;
        end else begin : g_cmp
            assign pending_mask[r] =
                (r_buf0_valid && (r_buf0_reg == REG_ADDR_WIDTH'(r))) ||
                (r_buf1_valid && (r_buf1_reg == REG_ADDR_WIDTH'(r)));
        end
    end

`ifdef REGFILE_WB_ARB_STATS_EN
    // Free-running statistics counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0   <= 32'd0;
            stat_grant1   <= 32'd0;
            stat_conflict <= 32'd0;
        end else begin
            if (w_grant0) begin
                stat_grant0 <= stat_grant0 + 32'd1;
            end
            if (w_grant1) begin
                stat_grant1 <= stat_grant1 + 32'd1;
            end
            if (r_buf0_valid && r_buf1_valid) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A behavioural
//               model (per-port slots with arrival timestamps, last-loser
//               pointer, array register file) predicts every output each
//               cycle under directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_reg, req1_reg, wr_reg;
    logic [DW-1:0] req0_data, req1_data, wr_data;
    logic          wr_en;
    logic [NR-1:0] pending_mask;
`ifdef REGFILE_WB_ARB_STATS_EN
    logic [31:0]   stat_grant0, stat_grant1, stat_conflict;
`endif

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_reg     (req0_reg),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_reg     (req1_reg),
        .req1_data    (req1_data),
        .wr_en        (wr_en),
        .wr_reg       (wr_reg),
        .wr_data      (wr_data),
        .pending_mask (pending_mask)
`ifdef REGFILE_WB_ARB_STATS_EN
        ,
        .stat_grant0  (stat_grant0),
        .stat_grant1  (stat_grant1),
        .stat_conflict(stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_v[2];
    logic [4:0]  m_reg[2];
    logic [31:0] m_data[2];
    int          m_stamp[2];
    int          m_rr;
    logic [31:0] m_rf[NR];
    int          m_g0, m_g1, m_conf;
    int          cyc;

    // Register file as seen through the DUT's write port
    logic [31:0] tb_rf[NR];
    int          commit_log[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input bit r,
                        input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                        output bit acc0, output bit acc1);
        int          g;
        bit          rdy0, rdy1;
        logic [31:0] mask, e_data;
        logic [4:0]  e_reg;
        @(negedge clk);
        rst = r;
        req0_valid = v0; req0_reg = a0; req0_data = d0;
        req1_valid = v1; req1_reg = a1; req1_data = d1;
        #1;
        g = -1;
        if (!r) begin
            if (m_v[0] && m_v[1]) begin
                if (m_reg[0] == m_reg[1]) g = (m_stamp[0] < m_stamp[1]) ? 0 : 1;
                else g = m_rr;
            end else if (m_v[0]) g = 0;
            else if (m_v[1]) g = 1;
        end
        rdy0 = !m_v[0] || (g == 0);
        rdy1 = !m_v[1] || (g == 1);
        mask = '0;
        for (int n = 0; n < 2; n++) if (m_v[n]) mask[m_reg[n]] = 1'b1;
        e_reg = '0; e_data = '0;
        if (g >= 0) begin e_reg = m_reg[g]; e_data = m_data[g]; end
        chk("req0_ready", 64'(req0_ready), 64'(rdy0));
        chk("req1_ready", 64'(req1_ready), 64'(rdy1));
        chk("wr_en", 64'(wr_en), 64'(g >= 0));
        chk("wr_reg", 64'(wr_reg), 64'(e_reg));
        chk("wr_data", 64'(wr_data), 64'(e_data));
        chk("pending_mask", 64'(pending_mask), 64'(mask));
        if (wr_en === 1'b1) begin
            commit_log.push_back(int'(wr_reg));
            if (wr_reg != 0) tb_rf[wr_reg] = wr_data;
        end
        acc0 = v0 && rdy0;
        acc1 = v1 && rdy1;
        @(posedge clk);
        if (r) begin
            m_v[0] = 0; m_v[1] = 0; m_rr = 0;
            m_g0 = 0; m_g1 = 0; m_conf = 0;
        end else begin
            if (m_v[0] && m_v[1]) m_conf++;
            if (g >= 0) begin
                m_rf[m_reg[g]] = m_data[g];
                m_v[g] = 0;
                m_rr = 1 - g;
                if (g == 0) m_g0++; else m_g1++;
            end
            if (v0 && rdy0 && a0 != 0) begin
                m_v[0] = 1; m_reg[0] = a0; m_data[0] = d0; m_stamp[0] = 2 * cyc;
            end
            if (v1 && rdy1 && a1 != 0) begin
                m_v[1] = 1; m_reg[1] = a1; m_data[1] = d1; m_stamp[1] = 2 * cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input bit r);
        bit x0, x1;
        step(r, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, x0, x1);
    endtask

    int          rr_exp[8] = '{1, 11, 2, 12, 3, 13, 4, 14};
    logic [31:0] prev20, prev21;

    initial begin
        bit a0, a1;
        int i0, i1;
        rst = 1'b1;
        req0_valid = 0; req0_reg = '0; req0_data = '0;
        req1_valid = 0; req1_reg = '0; req1_data = '0;
        cyc = 0; m_rr = 0; m_g0 = 0; m_g1 = 0; m_conf = 0;
        for (int k = 0; k < NR; k++) begin m_rf[k] = '0; tb_rf[k] = '0; end

        // Reset and post-reset idle state
        idle(1); idle(1); idle(0);

        // Single write to reg 5
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, a0, a1);
        chk("single_accept", 64'(a0), 64'd1);
        idle(0); idle(0);
        chk("single_rf5", 64'(tb_rf[5]), 64'hDEADBEEF);

        // x0 discard on port 1
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, a0, a1);
        idle(0); idle(0);
        chk("x0_no_commit", 64'(tb_rf[0]), 64'd0);

        // Round-robin streaming after reset
        idle(1);
        commit_log.delete();
        i0 = 0; i1 = 0;
        for (int k = 0; k < 30 && (i0 < 4 || i1 < 4 || m_v[0] || m_v[1]); k++) begin
            step(0, i0 < 4, 5'(1 + i0), $urandom, i1 < 4, 5'(11 + i1), $urandom, a0, a1);
            if (a0) i0++;
            if (a1) i1++;
        end
        chk("rr_drained", 64'(i0 + i1), 64'd8);
        chk("rr_len", 64'(commit_log.size()), 64'd8);
        for (int k = 0; k < 8; k++)
            if (k < commit_log.size()) chk("rr_order", 64'(commit_log[k]), 64'(rr_exp[k]));
`ifdef REGFILE_WB_ARB_STATS_EN
        chk("stat_grant0", 64'(stat_grant0), 64'd4);
        chk("stat_grant1", 64'(stat_grant1), 64'd4);
        chk("stat_conflict", 64'(stat_conflict), 64'd7);
`endif

        // Same-register ordering
        idle(1);
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1, a0, a1);
        step(0, 1, 5'd7, 32'h2, 0, 5'd0, 32'd0, a0, a1);
        idle(0); idle(0); idle(0);
        chk("same_reg_final", 64'(tb_rf[7]), 64'h2);

        // Reset with both buffers full
        step(0, 1, 5'd20, 32'h1111, 1, 5'd21, 32'h2222, a0, a1);
        idle(0); idle(0); idle(0);
        prev20 = tb_rf[20]; prev21 = tb_rf[21];
        step(0, 1, 5'd20, 32'hAAAA, 1, 5'd21, 32'hBBBB, a0, a1);
        idle(1);
        idle(0); idle(0);
        chk("rst_keep20", 64'(tb_rf[20]), 64'(prev20));
        chk("rst_keep21", 64'(tb_rf[21]), 64'(prev21));
        chk("rst_prev20", 64'(prev20), 64'h1111);

        // Randomized traffic, biased to a few registers to force conflicts
        for (int k = 0; k < 400; k++) begin
            bit r;
            logic [4:0] ra, rb;
            r  = ($urandom_range(0, 49) == 0);
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            step(r, 1'($urandom), ra, $urandom, 1'($urandom), rb, $urandom, a0, a1);
        end
        idle(0); idle(0); idle(0); idle(0);
        for (int k = 0; k < NR; k++) chk("final_rf", 64'(tb_rf[k]), 64'(m_rf[k]));
`ifdef REGFILE_WB_ARB_STATS_EN
        chk("final_grant0", 64'(stat_grant0), 64'(m_g0));
        chk("final_grant1", 64'(stat_grant1), 64'(m_g1));
        chk("final_conflict", 64'(stat_conflict), 64'(m_conf));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
